// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and writeback source encoding for the register-file writeback path
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with combinational grant
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t last;

  // On a tie the requester that was not granted most recently wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SRC_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= SRC_MEM;
    end else if (gnt != 2'b00) begin
      last <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file write port arbitration and in-flight destination scoreboard
module rf_wb_ctrl #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_reg,
  output logic                     iss_ready,
  input  logic [ADDR_W-1:0]        rd0_reg,
  input  logic [ADDR_W-1:0]        rd1_reg,
  output logic                     hazard0,
  output logic                     hazard1,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_dat,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_dat,
  output logic                     mem_ready,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_reg,
  output logic [DATA_W-1:0]        rf_dat,
  output logic [(2**ADDR_W)-1:0]   busy
);

  import rf_pkg::*;

  localparam int NR = 2 ** ADDR_W;

  logic [1:0]    gnt;
  logic          iss_fire;
  logic [NR-1:0] set_mask;
  logic [NR-1:0] clr_mask;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];

  assign iss_ready = !busy[iss_reg];
  assign hazard0   = busy[rd0_reg];
  assign hazard1   = busy[rd1_reg];

  assign iss_fire = iss_valid && iss_ready && (iss_reg != '0);
  assign set_mask = iss_fire ? (NR'(1) << iss_reg) : '0;
  assign clr_mask = rf_write ? (NR'(1) << rf_reg) : '0;

  // Issue and clear never target the same bit, so their order here is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~NR'(1);
    end
  end

  // Writes to x0 still consume the grant but never strobe the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      rf_reg   <= '0;
      rf_dat   <= '0;
    end else if (gnt[0]) begin
      rf_write <= (alu_reg != '0);
      rf_reg   <= alu_reg;
      rf_dat   <= alu_dat;
    end else if (gnt[1]) begin
      rf_write <= (mem_reg != '0);
      rf_reg   <= mem_reg;
      rf_dat   <= mem_dat;
    end else begin
      rf_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - scoreboard bench for the writeback controller
module tb_rf_wb_ctrl;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_reg = '0;
  logic        iss_ready;
  logic [4:0]  rd0_reg = '0;
  logic [4:0]  rd1_reg = '0;
  logic        hazard0, hazard1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_dat = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_reg = '0;
  logic [31:0] mem_dat = '0;
  logic        mem_ready;
  logic        rf_write;
  logic [4:0]  rf_reg;
  logic [31:0] rf_dat;
  logic [31:0] busy;

  int  checks = 0;
  int  errors = 0;
  bit  m_last = 1'b1;
  wr_t sb[$];
  wr_t aq[$];
  wr_t mq[$];

  rf_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .rd0_reg(rd0_reg), .rd1_reg(rd1_reg), .hazard0(hazard0), .hazard1(hazard1),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_dat(alu_dat), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_dat(mem_dat), .mem_ready(mem_ready),
    .rf_write(rf_write), .rf_reg(rf_reg), .rf_dat(rf_dat), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rf_write) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got reg %0d dat %h, required no write", rf_reg, rf_dat);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({rf_reg, rf_dat} !== {e.r, e.d}) begin
          errors++;
          $display("FAIL rf_write_data: got reg %0d dat %h, required reg %0d dat %h", rf_reg, rf_dat, e.r, e.d);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    step;
    iss_valid = 1'b1;
    iss_reg   = r;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready x%0d: got %b, required 1", r, iss_ready);
    end
    step;
    iss_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit         prev_g = 1'b0;
    logic [4:0] prev_r = '0;
    bit         exp_a, exp_m;
    wr_t        w;
    int         n = 0;
    while ((aq.size() > 0 || mq.size() > 0) && n < 32) begin
      step;
      n++;
      alu_valid = (aq.size() > 0);
      mem_valid = (mq.size() > 0);
      if (alu_valid) {alu_reg, alu_dat} = aq[0];
      if (mem_valid) {mem_reg, mem_dat} = mq[0];
      @(negedge clk);
      if (prev_g) begin
        checks++;
        if (rf_write !== (prev_r != 0)) begin
          errors++;
          $display("FAIL %s_strobe: got rf_write %b, required %b", name, rf_write, prev_r != 0);
        end
      end
      exp_a = alu_valid && (!mem_valid || m_last);
      exp_m = mem_valid && !exp_a;
      checks++;
      if ({alu_ready, mem_ready} !== {exp_a, exp_m}) begin
        errors++;
        $display("FAIL %s_grant: got alu %b mem %b, required alu %b mem %b", name, alu_ready, mem_ready, exp_a, exp_m);
      end
      prev_g = exp_a || exp_m;
      if (exp_a) begin
        w = aq.pop_front();
        m_last = 1'b0;
      end else if (exp_m) begin
        w = mq.pop_front();
        m_last = 1'b1;
      end
      if (prev_g) begin
        prev_r = w.r;
        if (w.r != 0) sb.push_back(w);
      end
    end
    checks++;
    if (aq.size() + mq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending, required 0", name, aq.size() + mq.size());
    end
    step;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_write !== (prev_g && prev_r != 0)) begin
      errors++;
      $display("FAIL %s_last_strobe: got %b, required %b", name, rf_write, prev_g && prev_r != 0);
    end
    step;
  endtask

  task automatic test_reset;
    rd0_reg = 5'd3;
    rd1_reg = 5'd4;
    #2;
    checks++;
    if ({busy, rf_write, rf_reg, rf_dat} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got busy %h wr %b reg %0d dat %h, required all 0", busy, rf_write, rf_reg, rf_dat);
    end
    checks++;
    if ({iss_ready, hazard0, hazard1} !== 3'b100) begin
      errors++;
      $display("FAIL reset_comb: got ready %b hz %b%b, required 1 00", iss_ready, hazard0, hazard1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw;
    rd0_reg = 5'd5;
    issue(5'd5);
    alu_valid = 1'b1;
    alu_reg   = 5'd5;
    alu_dat   = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({busy[5], hazard0, alu_ready} !== 3'b111) begin
      errors++;
      $display("FAIL raw_busy: got busy5 %b hz0 %b grant %b, required 111", busy[5], hazard0, alu_ready);
    end
    if (alu_ready) begin
      sb.push_back('{r: 5'd5, d: 32'hDEADBEEF});
      m_last = 1'b0;
    end
    step;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (hazard0 !== 1'b1) begin
      errors++;
      $display("FAIL raw_hazard_n1: got %b, required 1", hazard0);
    end
    step;
    @(negedge clk);
    checks++;
    if ({hazard0, busy} !== '0) begin
      errors++;
      $display("FAIL raw_hazard_n2: got hz0 %b busy %h, required 0", hazard0, busy);
    end
  endtask

  task automatic test_waw;
    issue(5'd7);
    iss_valid = 1'b1;
    iss_reg   = 5'd7;
    aq.push_back('{r: 5'd7, d: 32'h0000_0777});
    alu_valid = 1'b1;
    {alu_reg, alu_dat} = aq.pop_front();
    @(negedge clk);
    checks++;
    if ({iss_ready, alu_ready} !== 2'b01) begin
      errors++;
      $display("FAIL waw_stall_n: got ready %b grant %b, required 0 1", iss_ready, alu_ready);
    end
    sb.push_back('{r: 5'd7, d: 32'h0000_0777});
    m_last = 1'b0;
    step;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall_n1: got %b, required 0", iss_ready);
    end
    step;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_accept_n2: got %b, required 1", iss_ready);
    end
    step;
    iss_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++;
      $display("FAIL waw_rebusy: got %h, required 00000080", busy);
    end
    mq.push_back('{r: 5'd7, d: 32'h7777_0000});
    drain("waw_clean");
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 6; i++) issue(5'(i));
    for (int i = 1; i <= 6; i += 2) begin
      aq.push_back('{r: 5'(i), d: $urandom});
      mq.push_back('{r: 5'(i + 1), d: $urandom});
    end
    drain("rr");
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL rr_busy_clear: got %h, required 0", busy);
    end
  endtask

  task automatic test_x0;
    step;
    iss_valid = 1'b1;
    iss_reg   = 5'd0;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got %b, required 1", iss_ready);
    end
    step;
    iss_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL x0_busy: got %h, required 0", busy);
    end
    aq.push_back('{r: 5'd0, d: 32'h1234_5678});
    mq.push_back('{r: 5'd0, d: 32'h8765_4321});
    drain("x0");
  endtask

  task automatic test_mid_reset;
    rd0_reg = 5'd3;
    issue(5'd3);
    alu_valid = 1'b1;
    alu_reg   = 5'd3;
    alu_dat   = 32'hCAFE_0003;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_grant: got %b, required 1", alu_ready);
    end
    step;
    alu_valid = 1'b0;
    checks++;
    if ({rf_write, rf_reg} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL rst_pre_write: got wr %b reg %0d, required 1 3", rf_write, rf_reg);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rf_write, busy, hazard0, hazard1, iss_ready} !== {1'b0, 32'h0, 3'b001}) begin
      errors++;
      $display("FAIL rst_async: got wr %b busy %h hz %b%b ready %b, required 0 0 00 1", rf_write, busy, hazard0, hazard1, iss_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_last = 1'b1;
    issue(5'd1);
    issue(5'd2);
    aq.push_back('{r: 5'd1, d: 32'hA1A1_A1A1});
    mq.push_back('{r: 5'd2, d: 32'hB2B2_B2B2});
    drain("rst_tie");
  endtask

  task automatic test_concurrent;
    issue(5'd4);
    alu_valid = 1'b1;
    alu_reg   = 5'd4;
    alu_dat   = 32'h4444_4444;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL cc_grant: got %b, required 1", alu_ready);
    end
    sb.push_back('{r: 5'd4, d: 32'h4444_4444});
    m_last = 1'b0;
    step;
    alu_valid = 1'b0;
    iss_valid = 1'b1;
    iss_reg   = 5'd9;
    @(negedge clk);
    checks++;
    if ({iss_ready, busy[4], busy[9]} !== 3'b110) begin
      errors++;
      $display("FAIL cc_before: got ready %b b4 %b b9 %b, required 1 1 0", iss_ready, busy[4], busy[9]);
    end
    step;
    iss_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++;
      $display("FAIL cc_after: got %h, required 00000200", busy);
    end
    mq.push_back('{r: 5'd9, d: 32'h9999_9999});
    drain("cc_clean");
  endtask

  initial begin
    test_reset;
    test_raw;
    test_waw;
    test_back_to_back;
    test_x0;
    test_mid_reset;
    test_concurrent;
    step;
    checks++;
    if (sb.size() != 0 || busy !== '0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending busy %h, required 0 0", sb.size(), busy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
